id_operand_stage: RTL and testbench

ID_OPERAND_STAGE -- requirements
Module: id_operand_stage

---
 rtl/id_operand_stage_pkg.sv | 19 +
 rtl/id_operand_stage_fwd_select.sv | 45 ++++
 rtl/id_operand_stage.sv | 107 ++++++++++
 tb/tb_id_operand_stage.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_operand_stage_pkg.sv
// Shared widths and bus layouts for the ID operand stage.
package id_operand_stage_pkg;

  localparam int unsigned DataWDef  = 32;
  localparam int unsigned RaddrWDef = 5;

  // fs_to_ds bus: {inst[31:0], pc[31:0]}
  localparam int unsigned InstW     = 32;
  localparam int unsigned PcW       = 32;
  localparam int unsigned FsBusW    = InstW + PcW;
  localparam int unsigned FsPcLsb   = 0;
  localparam int unsigned FsInstLsb = PcW;

  // ds_to_es bus: {src1, src2, inst, pc}
  function automatic int unsigned ds_to_es_w(int unsigned data_w);
    return 2 * data_w + InstW + PcW;
  endfunction

endpackage

// File: rtl/id_operand_stage_fwd_select.sv
// Priority forwarding select for one operand: youngest matching source wins.
module id_operand_stage_fwd_select #(
  parameter int unsigned NumFwd = 3,
  parameter int unsigned DataW  = 32,
  parameter int unsigned RaddrW = 5
) (
  input  logic [RaddrW-1:0]        raddr_i,
  input  logic                     use_i,
  input  logic [DataW-1:0]         rf_rdata_i,
  input  logic [NumFwd-1:0]        fwd_we_i,
  input  logic [NumFwd*RaddrW-1:0] fwd_waddr_i,
  input  logic [NumFwd*DataW-1:0]  fwd_wdata_i,
  input  logic [NumFwd-1:0]        fwd_ready_i,
  output logic [DataW-1:0]         value_o,
  output logic                     not_ready_o
);

  logic [NumFwd-1:0] hit;
  logic              found;

  always_comb begin
    for (int unsigned i = 0; i < NumFwd; i++) begin
      hit[i] = fwd_we_i[i] && (fwd_waddr_i[i*RaddrW +: RaddrW] == raddr_i) &&
               (raddr_i != '0) && use_i;
    end
  end

  // An older ready producer must never hide a younger one still in flight.
  always_comb begin
    value_o     = rf_rdata_i;
    not_ready_o = 1'b0;
    found       = 1'b0;
    for (int unsigned i = 0; i < NumFwd; i++) begin
      if (hit[i] && !found) begin
        found       = 1'b1;
        value_o     = fwd_wdata_i[i*DataW +: DataW];
        not_ready_o = ~fwd_ready_i[i];
      end
    end
    if (raddr_i == '0) begin
      value_o = '0;
    end
  end

endmodule

// File: rtl/id_operand_stage.sv
// Decode-stage pipeline register with register-file read and operand forwarding.
module id_operand_stage
  import id_operand_stage_pkg::*;
#(
  parameter int unsigned NUM_FWD = 3,
  parameter int unsigned DATA_W  = DataWDef,
  parameter int unsigned RADDR_W = RaddrWDef
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          fs_valid,
  output logic                          ds_allowin,
  input  logic [FsBusW-1:0]             fs_to_ds_bus,
  output logic [InstW-1:0]              ds_inst,
  input  logic                          ds_src2_is_rd,
  input  logic                          ds_use_src1,
  input  logic                          ds_use_src2,
  output logic [RADDR_W-1:0]            rf_raddr1,
  output logic [RADDR_W-1:0]            rf_raddr2,
  input  logic [DATA_W-1:0]             rf_rdata1,
  input  logic [DATA_W-1:0]             rf_rdata2,
  input  logic [NUM_FWD-1:0]            fwd_we,
  input  logic [NUM_FWD*RADDR_W-1:0]    fwd_waddr,
  input  logic [NUM_FWD*DATA_W-1:0]     fwd_wdata,
  input  logic [NUM_FWD-1:0]            fwd_ready,
  input  logic                          flush,
  input  logic                          es_allowin,
  output logic                          ds_to_es_valid,
  output logic [ds_to_es_w(DATA_W)-1:0] ds_to_es_bus,
  output logic                          ds_stall
);

  logic              ds_valid_q, ds_valid_d;
  logic [FsBusW-1:0] bus_q, bus_d;
  logic [PcW-1:0]    ds_pc;
  logic [DATA_W-1:0] src1, src2;
  logic              src1_not_ready, src2_not_ready;
  logic              ds_ready_go;

  assign ds_inst   = bus_q[FsInstLsb +: InstW];
  assign ds_pc     = bus_q[FsPcLsb +: PcW];
  assign rf_raddr1 = RADDR_W'(ds_inst[9:5]);
  assign rf_raddr2 = ds_src2_is_rd ? RADDR_W'(ds_inst[4:0]) : RADDR_W'(ds_inst[14:10]);

  id_operand_stage_fwd_select #(
    .NumFwd(NUM_FWD),
    .DataW (DATA_W),
    .RaddrW(RADDR_W)
  ) u_fwd_src1 (
    .raddr_i    (rf_raddr1),
    .use_i      (ds_use_src1),
    .rf_rdata_i (rf_rdata1),
    .fwd_we_i   (fwd_we),
    .fwd_waddr_i(fwd_waddr),
    .fwd_wdata_i(fwd_wdata),
    .fwd_ready_i(fwd_ready),
    .value_o    (src1),
    .not_ready_o(src1_not_ready)
  );

  id_operand_stage_fwd_select #(
    .NumFwd(NUM_FWD),
    .DataW (DATA_W),
    .RaddrW(RADDR_W)
  ) u_fwd_src2 (
    .raddr_i    (rf_raddr2),
    .use_i      (ds_use_src2),
    .rf_rdata_i (rf_rdata2),
    .fwd_we_i   (fwd_we),
    .fwd_waddr_i(fwd_waddr),
    .fwd_wdata_i(fwd_wdata),
    .fwd_ready_i(fwd_ready),
    .value_o    (src2),
    .not_ready_o(src2_not_ready)
  );

  assign ds_stall       = ds_valid_q & (src1_not_ready | src2_not_ready);
  assign ds_ready_go    = ~ds_stall;
  assign ds_to_es_valid = ds_valid_q & ds_ready_go & ~flush;
  assign ds_allowin     = ~ds_valid_q | (ds_ready_go & es_allowin);
  assign ds_to_es_bus   = {src1, src2, ds_inst, ds_pc};

  // Flush kills the held instruction and blocks any capture on the same edge.
  always_comb begin
    ds_valid_d = ds_valid_q;
    bus_d      = bus_q;
    if (flush) begin
      ds_valid_d = 1'b0;
    end else if (ds_allowin) begin
      ds_valid_d = fs_valid;
      if (fs_valid) begin
        bus_d = fs_to_ds_bus;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ds_valid_q <= 1'b0;
      bus_q      <= '0;
    end else begin
      ds_valid_q <= ds_valid_d;
      bus_q      <= bus_d;
    end
  end

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage with a behavioural reference model.
module tb_id_operand_stage;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int NF = 3;
  localparam int BW = 2 * DW + 64;

  logic            clk, resetn, fs_valid, ds_allowin, flush, es_allowin;
  logic [63:0]     fs_to_ds_bus;
  logic [31:0]     ds_inst;
  logic            src2_is_rd, use1, use2;
  logic [RW-1:0]   rf_raddr1, rf_raddr2;
  logic [DW-1:0]   rf_rdata1, rf_rdata2;
  logic [NF-1:0]   fwd_we, fwd_ready;
  logic [NF*RW-1:0] fwd_waddr;
  logic [NF*DW-1:0] fwd_wdata;
  logic            ds_to_es_valid, ds_stall;
  logic [BW-1:0]   ds_to_es_bus;

  // Alternate source-count builds, exercised on the priority-match case only.
  logic [0:0]      we1, rdy1;
  logic [RW-1:0]   waddr1;
  logic [DW-1:0]   wdata1;
  logic [RW-1:0]   ra1_1, ra2_1;
  logic [DW-1:0]   rd1_1, rd2_1;
  logic            allowin_1, valid_1, stall_1;
  logic [31:0]     inst_1;
  logic [BW-1:0]   bus_1;
  logic [4:0]      we5, rdy5;
  logic [5*RW-1:0] waddr5;
  logic [5*DW-1:0] wdata5;
  logic [RW-1:0]   ra1_5, ra2_5;
  logic [DW-1:0]   rd1_5, rd2_5;
  logic            allowin_5, valid_5, stall_5;
  logic [31:0]     inst_5;
  logic [BW-1:0]   bus_5;

  int total = 0;
  int bad   = 0;
  int e_passes = 0;

  function automatic logic [DW-1:0] rf_val(logic [RW-1:0] a);
    return 32'h5000_0000 + {27'h0, a};
  endfunction

  function automatic logic [31:0] mk(logic [4:0] rd, logic [4:0] rj, logic [4:0] rk);
    return {17'h0, rk, rj, rd};
  endfunction

  assign rf_rdata1 = rf_val(rf_raddr1);
  assign rf_rdata2 = rf_val(rf_raddr2);
  assign rd1_1 = rf_val(ra1_1);
  assign rd2_1 = rf_val(ra2_1);
  assign rd1_5 = rf_val(ra1_5);
  assign rd2_5 = rf_val(ra2_5);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  id_operand_stage #(.NUM_FWD(NF), .DATA_W(DW), .RADDR_W(RW)) u_dut (
    .clk(clk), .resetn(resetn), .fs_valid(fs_valid), .ds_allowin(ds_allowin),
    .fs_to_ds_bus(fs_to_ds_bus), .ds_inst(ds_inst), .ds_src2_is_rd(src2_is_rd),
    .ds_use_src1(use1), .ds_use_src2(use2), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .fwd_we(fwd_we), .fwd_waddr(fwd_waddr),
    .fwd_wdata(fwd_wdata), .fwd_ready(fwd_ready), .flush(flush), .es_allowin(es_allowin),
    .ds_to_es_valid(ds_to_es_valid), .ds_to_es_bus(ds_to_es_bus), .ds_stall(ds_stall)
  );

  id_operand_stage #(.NUM_FWD(1), .DATA_W(DW), .RADDR_W(RW)) u_dut1 (
    .clk(clk), .resetn(resetn), .fs_valid(fs_valid), .ds_allowin(allowin_1),
    .fs_to_ds_bus(fs_to_ds_bus), .ds_inst(inst_1), .ds_src2_is_rd(src2_is_rd),
    .ds_use_src1(use1), .ds_use_src2(use2), .rf_raddr1(ra1_1), .rf_raddr2(ra2_1),
    .rf_rdata1(rd1_1), .rf_rdata2(rd2_1), .fwd_we(we1), .fwd_waddr(waddr1),
    .fwd_wdata(wdata1), .fwd_ready(rdy1), .flush(flush), .es_allowin(es_allowin),
    .ds_to_es_valid(valid_1), .ds_to_es_bus(bus_1), .ds_stall(stall_1)
  );

  id_operand_stage #(.NUM_FWD(5), .DATA_W(DW), .RADDR_W(RW)) u_dut5 (
    .clk(clk), .resetn(resetn), .fs_valid(fs_valid), .ds_allowin(allowin_5),
    .fs_to_ds_bus(fs_to_ds_bus), .ds_inst(inst_5), .ds_src2_is_rd(src2_is_rd),
    .ds_use_src1(use1), .ds_use_src2(use2), .rf_raddr1(ra1_5), .rf_raddr2(ra2_5),
    .rf_rdata1(rd1_5), .rf_rdata2(rd2_5), .fwd_we(we5), .fwd_waddr(waddr5),
    .fwd_wdata(wdata5), .fwd_ready(rdy5), .flush(flush), .es_allowin(es_allowin),
    .ds_to_es_valid(valid_5), .ds_to_es_bus(bus_5), .ds_stall(stall_5)
  );

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: the stage holds at most one instruction; operands come from the
  // youngest producer writing the same nonzero register, else the register file.
  function automatic logic [DW:0] resolve(logic [RW-1:0] ra, logic use_op, logic [DW-1:0] rf,
                                          logic [NF-1:0] we, logic [NF*RW-1:0] wa,
                                          logic [NF*DW-1:0] wd, logic [NF-1:0] rdy);
    if (ra == 0) return '0;
    if (use_op) begin
      for (int i = 0; i < NF; i++) begin
        if (we[i] && wa[i*RW +: RW] == ra) return {~rdy[i], wd[i*DW +: DW]};
      end
    end
    return {1'b0, rf};
  endfunction

  logic          m_valid;
  logic [63:0]   m_held;
  logic [31:0]   m_inst;
  logic [RW-1:0] m_ra1, m_ra2;
  logic [DW:0]   m_r1, m_r2;
  logic          m_stall, m_to_es, m_allowin;
  logic [BW-1:0] m_bus;

  always_comb begin
    m_inst    = m_held[63:32];
    m_ra1     = m_inst[9:5];
    m_ra2     = src2_is_rd ? m_inst[4:0] : m_inst[14:10];
    m_r1      = resolve(m_ra1, use1, rf_val(m_ra1), fwd_we, fwd_waddr, fwd_wdata, fwd_ready);
    m_r2      = resolve(m_ra2, use2, rf_val(m_ra2), fwd_we, fwd_waddr, fwd_wdata, fwd_ready);
    m_stall   = m_valid && (m_r1[DW] || m_r2[DW]);
    m_to_es   = m_valid && !m_stall && !flush;
    m_allowin = !m_valid || (!m_stall && es_allowin);
    m_bus     = {m_r1[DW-1:0], m_r2[DW-1:0], m_held};
  end

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_valid <= 1'b0;
      m_held  <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
    end else if (m_allowin) begin
      m_valid <= fs_valid;
      if (fs_valid) m_held <= fs_to_ds_bus;
    end
  end

  always @(negedge clk) begin
    chk("allowin", BW'(ds_allowin), BW'(m_allowin));
    chk("to_es_valid", BW'(ds_to_es_valid), BW'(m_to_es));
    chk("stall", BW'(ds_stall), BW'(m_stall));
    chk("ds_inst", BW'(ds_inst), BW'(m_inst));
    chk("raddr1", BW'(rf_raddr1), BW'(m_ra1));
    chk("raddr2", BW'(rf_raddr2), BW'(m_ra2));
    if (m_to_es) chk("to_es_bus", ds_to_es_bus, m_bus);
    if (resetn && ds_to_es_valid && es_allowin && ds_to_es_bus[31:0] == 32'hE00) e_passes++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fwd(input int i, input logic we, input logic [RW-1:0] a,
                         input logic [DW-1:0] d, input logic rdy);
    fwd_we[i] = we;
    fwd_waddr[i*RW +: RW] = a;
    fwd_wdata[i*DW +: DW] = d;
    fwd_ready[i] = rdy;
  endtask

  task automatic clr_fwd();
    fwd_we = '0; fwd_waddr = '0; fwd_wdata = '0; fwd_ready = '1;
    we1 = '0; waddr1 = '0; wdata1 = '0; rdy1 = '1;
    we5 = '0; waddr5 = '0; wdata5 = '0; rdy5 = '1;
  endtask

  task automatic send(input logic [31:0] inst, input logic [31:0] pc);
    fs_valid = 1'b1;
    fs_to_ds_bus = {inst, pc};
  endtask

  logic [31:0] inst_a, inst_b, inst_c, inst_d, inst_e, inst_f, inst_g, inst_h, inst_x;

  initial begin
    inst_a = mk(5'd1, 5'd5, 5'd2);
    inst_b = mk(5'd3, 5'd0, 5'd7);
    inst_c = mk(5'd4, 5'd0, 5'd0);
    inst_d = mk(5'd6, 5'd9, 5'd0);
    inst_x = mk(5'd1, 5'd1, 5'd1);
    inst_e = mk(5'd8, 5'd10, 5'd11);
    inst_f = mk(5'd2, 5'd3, 5'd4);
    inst_g = mk(5'd12, 5'd11, 5'd0);
    inst_h = mk(5'd13, 5'd14, 5'd15);
    resetn = 1'b0; fs_valid = 1'b0; fs_to_ds_bus = '0; flush = 1'b0; es_allowin = 1'b1;
    src2_is_rd = 1'b0; use1 = 1'b0; use2 = 1'b0;
    clr_fwd();
    tick();
    chk("rst_allowin", BW'(ds_allowin), BW'(1));
    chk("rst_to_es", BW'(ds_to_es_valid), BW'(0));
    chk("rst_stall", BW'(ds_stall), BW'(0));
    chk("rst_inst", BW'(ds_inst), BW'(0));
    tick();
    resetn = 1'b1;

    // Youngest matching source wins over an older one.
    send(inst_a, 32'h100); use1 = 1'b1;
    set_fwd(0, 1'b1, 5'd5, 32'hAAAA, 1'b1);
    set_fwd(2, 1'b1, 5'd5, 32'hBBBB, 1'b1);
    we1 = 1'b1; waddr1 = 5'd5; wdata1 = 32'hAAAA;
    we5 = 5'b10101; waddr5 = {5'd5, 5'd0, 5'd5, 5'd0, 5'd5};
    wdata5 = {32'hCCCC, 32'h0, 32'hBBBB, 32'h0, 32'hAAAA};
    tick();
    send(inst_b, 32'h104);
    #1;
    chk("prio_src1", BW'(ds_to_es_bus[127:96]), BW'(32'hAAAA));
    chk("prio_stall", BW'(ds_stall), BW'(0));
    chk("prio_to_es", BW'(ds_to_es_valid), BW'(1));
    chk("nf1_src1", BW'(bus_1[127:96]), BW'(32'hAAAA));
    chk("nf1_stall", BW'(stall_1), BW'(0));
    chk("nf5_src1", BW'(bus_5[127:96]), BW'(32'hAAAA));
    chk("nf5_stall", BW'(stall_5), BW'(0));

    // Not-ready youngest producer stalls even when an older one is ready.
    tick();
    clr_fwd(); use1 = 1'b0; use2 = 1'b1;
    set_fwd(0, 1'b1, 5'd7, 32'hDEAD, 1'b0);
    set_fwd(1, 1'b1, 5'd7, 32'h5555, 1'b1);
    send(inst_c, 32'h108);
    #1;
    chk("hz_stall", BW'(ds_stall), BW'(1));
    chk("hz_allowin", BW'(ds_allowin), BW'(0));
    chk("hz_to_es", BW'(ds_to_es_valid), BW'(0));
    tick();
    set_fwd(0, 1'b1, 5'd7, 32'h1234, 1'b1);
    #1;
    chk("hz_rel_stall", BW'(ds_stall), BW'(0));
    chk("hz_rel_to_es", BW'(ds_to_es_valid), BW'(1));
    chk("hz_rel_src2", BW'(ds_to_es_bus[95:64]), BW'(32'h1234));
    chk("hz_rel_inst", BW'(ds_inst), BW'(inst_b));

    // Register 0 never forwards.
    tick();
    use1 = 1'b1; use2 = 1'b0;
    for (int i = 0; i < NF; i++) set_fwd(i, 1'b1, 5'd0, 32'hFFFF, 1'b0);
    send(inst_d, 32'h10C);
    #1;
    chk("r0_src1", BW'(ds_to_es_bus[127:96]), BW'(0));
    chk("r0_stall", BW'(ds_stall), BW'(0));
    chk("r0_inst", BW'(ds_inst), BW'(inst_c));

    // Flush during a stall.
    tick();
    clr_fwd();
    set_fwd(0, 1'b1, 5'd9, 32'h0, 1'b0);
    send(inst_x, 32'h110);
    #1;
    chk("fl_stall", BW'(ds_stall), BW'(1));
    tick();
    flush = 1'b1;
    #1;
    chk("fl_to_es", BW'(ds_to_es_valid), BW'(0));
    tick();
    flush = 1'b0; fs_valid = 1'b0; clr_fwd();
    #1;
    chk("fl_after_to_es", BW'(ds_to_es_valid), BW'(0));
    chk("fl_after_allowin", BW'(ds_allowin), BW'(1));
    chk("fl_after_inst", BW'(ds_inst), BW'(inst_d));

    // EX backpressure for three cycles.
    send(inst_e, 32'hE00); use2 = 1'b1;
    tick();
    es_allowin = 1'b0;
    send(inst_f, 32'h114);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_allowin", BW'(ds_allowin), BW'(0));
      chk("bp_inst", BW'(ds_inst), BW'(inst_e));
      tick();
    end
    es_allowin = 1'b1;
    #1;
    chk("bp_rel_to_es", BW'(ds_to_es_valid), BW'(1));
    tick();
    fs_valid = 1'b0;
    #1;
    chk("bp_next_inst", BW'(ds_inst), BW'(inst_f));
    tick();
    #1;
    chk("bp_drain", BW'(ds_to_es_valid), BW'(0));
    chk("bp_once", BW'(e_passes), BW'(1));

    // Reset in the middle of a stall.
    send(inst_g, 32'h118); use2 = 1'b0;
    set_fwd(0, 1'b1, 5'd11, 32'h0, 1'b0);
    tick();
    fs_valid = 1'b0;
    #1;
    chk("rs_pre_stall", BW'(ds_stall), BW'(1));
    #1;
    resetn = 1'b0;
    #1;
    chk("rs_to_es", BW'(ds_to_es_valid), BW'(0));
    chk("rs_allowin", BW'(ds_allowin), BW'(1));
    chk("rs_stall", BW'(ds_stall), BW'(0));
    chk("rs_inst", BW'(ds_inst), BW'(0));
    tick();
    tick();
    resetn = 1'b1; clr_fwd();
    #1;
    chk("rs_empty", BW'(ds_to_es_valid), BW'(0));
    send(inst_h, 32'h11C);
    tick();
    fs_valid = 1'b0;
    #1;
    chk("rs_resume_to_es", BW'(ds_to_es_valid), BW'(1));
    chk("rs_resume_pc", BW'(ds_to_es_bus[31:0]), BW'(32'h11C));
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
